// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and default width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_dataflow.sv
// Existing single-bit full adder cell, purely combinational.
module full_adder_dataflow (
  output logic sum,
  output logic carry_out,
  input  logic a,
  input  logic b,
  input  logic carry_in
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: streams operands LSB first through one full adder cell
// and reports the registered result with a start/done handshake.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | ready; start captures operands and carry
// ST_RUN  | one operand bit pair added per clock, WIDTH clocks total
// ST_DONE | one-cycle done pulse, result valid; then back to ST_IDLE
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] s_shift;

  full_adder_dataflow u_fa (
    .sum       (fa_sum),
    .carry_out (fa_cout),
    .a         (a_sr_q[0]),
    .b         (b_sr_q[0]),
    .carry_in  (c_q)
  );

  // Written as a cast of a shifted concatenation so WIDTH=1 needs no special case.
  assign s_shift = WIDTH'({fa_sum, s_sr_q} >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          c_d     = carry_in;
          cnt_d   = '0;
          s_sr_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_sr_d = s_shift;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        c_d    = fa_cout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = s_shift;
          cout_d  = fa_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready     = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign sum_out   = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8, plus a WIDTH=1 instance.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       carry_in = 1'b0;
  logic       ready, busy, done, carry_out;
  logic [7:0] sum_out;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       ready1, busy1, done1, cout1;
  logic [0:0] sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .carry_in(carry_in), .ready(ready), .busy(busy), .done(done),
    .sum_out(sum_out), .carry_out(carry_out)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a_in(a1), .b_in(b1),
    .carry_in(cin1), .ready(ready1), .busy(busy1), .done(done1),
    .sum_out(sum1), .carry_out(cout1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts one operation on the 8-bit instance and waits for done.
  // lat = edges after the accepting edge until done is seen; busy_n = cycles with busy high.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         output int lat, output int busy_n, output bit tmo);
    a_in = a; b_in = b; carry_in = cin; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0; busy_n = 0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin tmo = 1'b0; break; end
      if (busy) busy_n++;
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (sum_out !== 8'h00) begin errors++; $display("FAIL reset_sum got %h exp 00", sum_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", carry_out); end
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready_w1 got %b exp 1", ready1); end
  endtask

  task automatic test_basic;
    int lat, bn; bit tmo;
    run_op8(8'h03, 8'h05, 1'b0, lat, bn, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL basic_timeout got no done exp done"); end
    checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
    checks++; if (bn != 8) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", bn); end
    checks++; if (sum_out !== 8'h08) begin errors++; $display("FAIL basic_sum got %h exp 08", sum_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL basic_cout got %b exp 0", carry_out); end
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", done); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b exp 1", ready); end
    checks++; if (sum_out !== 8'h08) begin errors++; $display("FAIL basic_sum_hold got %h exp 08", sum_out); end
  endtask

  task automatic test_carry;
    int lat, bn; bit tmo;
    run_op8(8'hFF, 8'h01, 1'b0, lat, bn, tmo);
    checks++; if (tmo || sum_out !== 8'h00) begin errors++; $display("FAIL carry1_sum got %h exp 00", sum_out); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL carry1_cout got %b exp 1", carry_out); end
    tick;
    run_op8(8'hFF, 8'hFF, 1'b1, lat, bn, tmo);
    checks++; if (tmo || sum_out !== 8'hFF) begin errors++; $display("FAIL carry2_sum got %h exp ff", sum_out); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL carry2_cout got %b exp 1", carry_out); end
    tick;
  endtask

  task automatic test_ignored_start;
    bit seen = 1'b0;
    a_in = 8'h10; b_in = 8'h20; carry_in = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin seen = 1'b1; break; end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ign_ready_run got %b exp 0 at %0d", ready, i); end
      if (i == 2) begin start = 1'b1; a_in = 8'hAA; b_in = 8'h55; carry_in = 1'b1; end
      else begin start = 1'b0; a_in = 8'(i * 37 + 5); b_in = 8'(i * 11 + 3); end
      tick;
    end
    checks++; if (!seen) begin errors++; $display("FAIL ign_timeout got no done exp done"); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ign_ready_done got %b exp 0", ready); end
    checks++; if (sum_out !== 8'h30) begin errors++; $display("FAIL ign_sum got %h exp 30", sum_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL ign_cout got %b exp 0", carry_out); end
    start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
    tick;
    start = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ign_done_start got ready %b busy %b exp 1 0", ready, busy); end
    tick;
    checks++; if (busy !== 1'b0 || sum_out !== 8'h30) begin errors++; $display("FAIL ign_no_trace got busy %b sum %h exp 0 30", busy, sum_out); end
  endtask

  task automatic test_reset_mid_run;
    int lat, bn; bit tmo;
    a_in = 8'h7F; b_in = 8'h01; carry_in = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got %b exp 1", busy); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags got r%b b%b d%b exp 1 0 0", ready, busy, done); end
    checks++; if (sum_out !== 8'h00 || carry_out !== 1'b0) begin
      errors++; $display("FAIL rst_mid_result got %b %h exp 0 00", carry_out, sum_out); end
    run_op8(8'h7F, 8'h01, 1'b0, lat, bn, tmo);
    checks++; if (tmo || sum_out !== 8'h80 || carry_out !== 1'b0) begin
      errors++; $display("FAIL rst_mid_rerun got %b %h exp 0 80", carry_out, sum_out); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [7:0] op_a [3] = '{8'h12, 8'hC8, 8'h81};
    logic [7:0] op_b [3] = '{8'h34, 8'h64, 8'h7F};
    logic       op_c [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] ex_s [3] = '{8'h46, 8'h2D, 8'h00};
    logic       ex_c [3] = '{1'b0, 1'b1, 1'b1};
    int done_cyc [3];
    int ld = 1, k = 0, cyc = 0;
    a_in = op_a[0]; b_in = op_b[0]; carry_in = op_c[0]; start = 1'b1;
    while (k < 3 && cyc < 100) begin
      tick;
      cyc++;
      if (done) begin
        done_cyc[k] = cyc;
        checks++; if (sum_out !== ex_s[k] || carry_out !== ex_c[k]) begin
          errors++; $display("FAIL b2b_result%0d got %b %h exp %b %h", k, carry_out, sum_out, ex_c[k], ex_s[k]); end
        k++;
      end
      if (ready && ld < 3) begin a_in = op_a[ld]; b_in = op_b[ld]; carry_in = op_c[ld]; ld++; end
      else if (busy && ld == 3) start = 1'b0;
    end
    start = 1'b0;
    checks++; if (k != 3) begin errors++; $display("FAIL b2b_timeout got %0d dones exp 3", k); end
    else begin
      checks++; if (done_cyc[1] - done_cyc[0] != 10) begin
        errors++; $display("FAIL b2b_period01 got %0d exp 10", done_cyc[1] - done_cyc[0]); end
      checks++; if (done_cyc[2] - done_cyc[1] != 10) begin
        errors++; $display("FAIL b2b_period12 got %0d exp 10", done_cyc[2] - done_cyc[1]); end
    end
    tick; tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got busy %b exp 0", busy); end
  endtask

  task automatic test_random;
    int lat, bn; bit tmo;
    logic [7:0] a, b; logic c; logic [8:0] ex;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); c = 1'($urandom_range(0, 1));
      ex = {1'b0, a} + {1'b0, b} + {8'd0, c};
      run_op8(a, b, c, lat, bn, tmo);
      checks++; if (tmo || lat != 8 || {carry_out, sum_out} !== ex) begin
        errors++; $display("FAIL rand%0d got %h lat %0d exp %h lat 8 (a %h b %h c %b)", i, {carry_out, sum_out}, lat, ex, a, b, c); end
      tick;
    end
  endtask

  task automatic test_width1;
    logic ta [3] = '{1'b1, 1'b0, 1'b1};
    logic tb [3] = '{1'b1, 1'b1, 1'b0};
    logic tc [3] = '{1'b1, 1'b0, 1'b1};
    logic es [3] = '{1'b1, 1'b1, 1'b0};
    logic ec [3] = '{1'b1, 1'b0, 1'b1};
    int lat;
    for (int t = 0; t < 3; t++) begin
      a1 = ta[t]; b1 = tb[t]; cin1 = tc[t]; start1 = 1'b1;
      tick;
      start1 = 1'b0;
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL w1_busy%0d got %b exp 1", t, busy1); end
      lat = 0;
      while (!done1 && lat < 10) begin tick; lat++; end
      checks++; if (lat != 1) begin errors++; $display("FAIL w1_latency%0d got %0d exp 1", t, lat); end
      checks++; if (sum1 !== es[t] || cout1 !== ec[t]) begin
        errors++; $display("FAIL w1_result%0d got %b%b exp %b%b", t, cout1, sum1, ec[t], es[t]); end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_ignored_start;
    test_reset_mid_run;
    test_back_to_back;
    test_width1;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder controller that reuses the existing single-bit `full_adder_dataflow` cell.
- It owns the operand shift registers, the carry flip-flop and the bit counter, and feeds the full adder one bit per clock, LSB first.
- It runs a start/done handshake, so a single 1-bit adder can serve wide additions in area-constrained datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH) (minimum 1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured when start is accepted.
- b_in  input  WIDTH  operand B; captured when start is accepted.
- carry_in  input  1  initial carry; captured when start is accepted.
- ready  output  1  high in IDLE; start is accepted only while ready=1.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE; result valid.
- sum_out  output  WIDTH  registered sum; held until the next completion or reset.
- carry_out  output  1  registered final carry; held with sum_out.

Behaviour:
- States: IDLE, RUN, DONE, binary encoded.
- Reset (sync; takes priority over every other event, including mid-RUN):
  - state=IDLE; ready=1; busy=0; done=0.
  - sum_out=0; carry_out=0.
  - Internal shift registers, carry flop and counter cleared.
- IDLE:
  - ready=1.
  - start=1 at edge E0: load A_sr<=a_in, B_sr<=b_in, c_reg<=carry_in, cnt<=0, S_sr<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - The full adder sees a=A_sr[0], b=B_sr[0], carry_in=c_reg. The adder is combinational; the controller provides all state.
  - Each edge:
    - S_sr <= {fa_sum, S_sr[WIDTH-1:1]}
    - A_sr and B_sr shift right, zero fill.
    - c_reg <= fa_carry_out
    - cnt <= cnt+1
  - At the edge where cnt==WIDTH-1:
    - sum_out <= {fa_sum, S_sr[WIDTH-1:1]}
    - carry_out <= fa_carry_out
    - go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - start sampled at edge E0 → done high in the cycle following edge E0+WIDTH.
  - Start-to-start period is WIDTH+2 cycles.
- Handshake:
  - start while busy or in DONE is ignored; no queuing, and operands and result are unaffected.
  - start held high continuously produces back-to-back operations, one every WIDTH+2 cycles.
- Arithmetic: {carry_out, sum_out} = a_in + b_in + carry_in, exact modulo 2^(WIDTH+1).
- sum_out and carry_out change only at the completion edge or on reset. Input changes during RUN have no effect.
- WIDTH=1: RUN lasts exactly one cycle; the counter is a single bit and compares against 0.
- No X propagation: every register is reset.

Decomposition:
- Shared package/include `serial_adder_pkg`:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - default WIDTH constant.
- One sub-module instance: `full_adder_dataflow` (existing cell), port order (sum, carry_out, a, b, carry_in). Do not re-implement the adder inline.
- FSM, counter and shift registers stay in serial_adder_ctrl. There is no further split.

Test Plan:
- WIDTH=8, a_in=8'h03, b_in=8'h05, carry_in=0, start pulse at E0 → done high only in the cycle after E0+8; sum_out=8'h08; carry_out=0; busy high for exactly 8 cycles.
- a_in=8'hFF, b_in=8'h01, carry_in=0 → sum_out=8'h00, carry_out=1. Then a_in=8'hFF, b_in=8'hFF, carry_in=1 → sum_out=8'hFF, carry_out=1.
- During RUN of 8'h10+8'h20, pulse start with a_in=8'hAA, b_in=8'h55, and change a_in/b_in every cycle → result 8'h30 with carry 0; the ignored start leaves no trace; ready low throughout RUN/DONE.
- Assert reset on the 4th RUN cycle of 8'h7F+8'h01 → next cycle: IDLE, ready=1, busy=0, done=0, sum_out=0, carry_out=0. Then 8'h7F+8'h01 → 8'h80, carry 0.
- start held high for 3 operations with changing operands → done pulses exactly WIDTH+2 cycles apart; each result matches a+b+cin.
- WIDTH=1 build: 1+1 with cin=1 → sum_out=1, carry_out=1, done 2 cycles after start. Also run a 200-iteration random compare against a+b+cin at WIDTH=8.
